// File: rtl/bus_timer_if.sv
// Simple single-cycle system bus carrying byte-strobed writes and registered
// read responses.
interface bus_timer_if;
    logic [31:0] addr;
    logic        read_req;
    logic        write_req;
    logic [3:0]  byte_enable;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        read_data_valid;

    modport follower (
        input  addr, read_req, write_req, byte_enable, write_data,
        output read_data, read_data_valid
    );

    modport leader (
        output addr, read_req, write_req, byte_enable, write_data,
        input  read_data, read_data_valid
    );
endinterface

// File: rtl/bus_timer.sv
// Prescaled 32-bit match timer with CTRL/COUNT/COMPARE/STATUS registers.
// The timer supports auto-reload or one-shot operation and drives a level interrupt.
module bus_timer #(
    parameter int          PrescaleBits = 8,
    parameter logic [31:0] CompareReset = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    bus_timer_if.follower bus,
    output logic         irq
);

    localparam int CtrlMsb = 8 + PrescaleBits - 1;

    logic                    enable_q, enable_d;
    logic                    auto_reload_q, auto_reload_d;
    logic                    irq_en_q, irq_en_d;
    logic [PrescaleBits-1:0] prescale_q, prescale_d;
    logic [PrescaleBits-1:0] pre_cnt_q, pre_cnt_d;
    logic [31:0]             count_q, count_d;
    logic [31:0]             compare_q, compare_d;
    logic                    match_q, match_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    rvalid_q, rvalid_d;

    logic [31:0] wmask, ctrl_word, ctrl_new, reg_rd;
    logic        wr_ctrl, wr_count, wr_compare, wr_status, rd_en;
    logic        tick, hit;
    logic        unused_addr;

    function automatic logic [31:0] merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [31:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

    assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};

    always_comb begin
        wmask      = {{8{bus.byte_enable[3]}}, {8{bus.byte_enable[2]}},
                      {8{bus.byte_enable[1]}}, {8{bus.byte_enable[0]}}};
        wr_ctrl    = bus.write_req && (bus.addr[3:2] == 2'd0);
        wr_count   = bus.write_req && (bus.addr[3:2] == 2'd1);
        wr_compare = bus.write_req && (bus.addr[3:2] == 2'd2);
        wr_status  = bus.write_req && (bus.addr[3:2] == 2'd3);
        // A simultaneous write suppresses the read entirely.
        rd_en      = bus.read_req && !bus.write_req;

        ctrl_word              = '0;
        ctrl_word[0]           = enable_q;
        ctrl_word[1]           = auto_reload_q;
        ctrl_word[2]           = irq_en_q;
        ctrl_word[CtrlMsb:8]   = prescale_q;
        ctrl_new               = merge(ctrl_word, bus.write_data, wmask);

        case (bus.addr[3:2])
            2'd0:    reg_rd = ctrl_word;
            2'd1:    reg_rd = count_q;
            2'd2:    reg_rd = compare_q;
            default: reg_rd = {31'b0, match_q};
        endcase

        tick = enable_q && (pre_cnt_q == prescale_q);
        hit  = tick && (count_q == compare_q);
    end

    always_comb begin
        enable_d      = enable_q;
        auto_reload_d = auto_reload_q;
        irq_en_d      = irq_en_q;
        prescale_d    = prescale_q;
        count_d       = count_q;
        compare_d     = compare_q;
        match_d       = match_q;

        if (!enable_q || tick) pre_cnt_d = '0;
        else                   pre_cnt_d = pre_cnt_q + PrescaleBits'(1);

        // Clear first so a same-cycle match set takes priority.
        if (wr_status && bus.byte_enable[0] && bus.write_data[0]) match_d = 1'b0;

        if (tick) begin
            if (hit) begin
                match_d = 1'b1;
                if (auto_reload_q) count_d  = '0;
                else               enable_d = 1'b0;
            end else begin
                count_d = count_q + 32'd1;
            end
        end

        if (wr_count)   count_d   = merge(count_q, bus.write_data, wmask);
        if (wr_compare) compare_d = merge(compare_q, bus.write_data, wmask);
        if (wr_ctrl) begin
            enable_d      = ctrl_new[0];
            auto_reload_d = ctrl_new[1];
            irq_en_d      = ctrl_new[2];
            prescale_d    = ctrl_new[CtrlMsb:8];
        end

        rvalid_d = rd_en;
        rdata_d  = rd_en ? reg_rd : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enable_q      <= 1'b0;
            auto_reload_q <= 1'b0;
            irq_en_q      <= 1'b0;
            prescale_q    <= '0;
            pre_cnt_q     <= '0;
            count_q       <= '0;
            compare_q     <= CompareReset;
            match_q       <= 1'b0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
        end else begin
            enable_q      <= enable_d;
            auto_reload_q <= auto_reload_d;
            irq_en_q      <= irq_en_d;
            prescale_q    <= prescale_d;
            pre_cnt_q     <= pre_cnt_d;
            count_q       <= count_d;
            compare_q     <= compare_d;
            match_q       <= match_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
        end
    end

    assign bus.read_data       = rdata_q;
    assign bus.read_data_valid = rvalid_q;
    assign irq                 = match_q & irq_en_q;

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter PrescaleBits, default 8, width of the prescale field and the prescale counter.
REQ-002 Parameter CompareReset, default 32'hFFFF_FFFF, reset value of COMPARE.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 bus  bus.follower  --  system bus follower port; signals as in REQ-006..REQ-012.
REQ-006 bus.addr  input  32  masked byte address; only addr[3:2] decoded, all other bits ignored (aliasing).
REQ-007 bus.read_req  input  1  single-cycle read request.
REQ-008 bus.write_req  input  1  single-cycle write request.
REQ-009 bus.byte_enable  input  4  per-byte write strobes; bit n enables write_data[8n+7:8n].
REQ-010 bus.write_data  input  32  write payload.
REQ-011 bus.read_data  output  32  read response data.
REQ-012 bus.read_data_valid  output  1  one-cycle read response strobe.
REQ-013 irq  output  1  level interrupt, high while STATUS.match and CTRL.irq_en are both 1.

Function
REQ-014 Register map: 0x0 CTRL, 0x4 COUNT, 0x8 COMPARE, 0xC STATUS.
REQ-015 CTRL fields: bit0 enable, bit1 auto_reload, bit2 irq_en, bits[8+PrescaleBits-1:8] prescale; all other bits read 0 and ignore writes.
REQ-016 STATUS fields: bit0 match; writing 1 clears it, writing 0 leaves it unchanged; other bits read 0.
REQ-017 Read response: read_data_valid asserted exactly one cycle after read_req, for exactly one cycle.
REQ-018 read_data carries the register value as sampled in the read_req cycle, before any same-cycle state update.
REQ-019 read_data is 0 whenever read_data_valid is 0.
REQ-020 read_data_valid is 0 whenever no read response is being returned.
REQ-021 Writes produce no response and take effect at the end of the write_req cycle, honouring byte_enable per byte.
REQ-022 If read_req and write_req are both high in the same cycle, the block performs the write only; no response is returned.
REQ-023 Back-to-back reads on consecutive cycles each receive a response on consecutive cycles, with no stall.
REQ-024 Prescale counter (PrescaleBits wide): cleared while enable=0; while enable=1 it increments each cycle.
REQ-025 When the prescale counter equals prescale, it wraps to 0 and generates a one-cycle tick; prescale=0 gives a tick every cycle.
REQ-026 On a tick with COUNT==COMPARE:
  - set match;
  - if auto_reload=1, COUNT becomes 0;
  - otherwise COUNT holds and enable clears (one-shot).
REQ-027 On a tick with COUNT!=COMPARE, COUNT increments by 1 modulo 2^32 (0xFFFF_FFFF wraps to 0).
REQ-028 A bus write to COUNT in the same cycle as a tick wins over the increment or reload.
REQ-029 A bus write to CTRL in the same cycle as a one-shot enable clear wins over the clear.
REQ-030 A match set and a W1C clear of STATUS in the same cycle leave match=1 (set wins).
REQ-031 irq is derived from registered state only; it rises the cycle after the tick that sets match.

Reset
REQ-032 While reset=1, the following hold immediately (asynchronously):
  - CTRL=0, COUNT=0, COMPARE=CompareReset, STATUS=0;
  - prescale counter=0;
  - read_data=0, read_data_valid=0, irq=0.
REQ-033 A read in flight when reset asserts is dropped; no response is returned after reset deasserts.
REQ-034 After reset deasserts, the first request is accepted in the following cycle.

Verification
REQ-035 Reset defaults: read 0x0, 0x4, 0x8, 0xC -> 0x0, 0x0, 0xFFFF_FFFF, 0x0, each valid exactly one cycle after its request.
REQ-036 Auto-reload with irq:
  - stimulus: COMPARE=3, CTRL=0x7 (prescale 0);
  - response: COUNT goes 0,1,2,3 then 0; match sets on the 4th tick; irq rises the next cycle;
  - then write 0xC=1 -> irq low the next cycle.
REQ-037 One-shot with prescale:
  - stimulus: COMPARE=2, CTRL=0x0000_0301 (prescale 3);
  - response: COUNT increments every 4 cycles and stops at 2; enable reads 0; irq stays 0.
REQ-038 Byte-lane write: COMPARE=0x1122_3344, then write 0xAABB_CCDD with byte_enable=4'b0101 -> COMPARE reads 0x11BB_33DD.
REQ-039 Collisions:
  - COUNT write of 0x100 coincident with a tick -> COUNT reads 0x100;
  - W1C of STATUS coincident with a match -> match reads 1.
REQ-040 Wrap: COUNT=0xFFFF_FFFF, COMPARE=5, enable on -> COUNT reads 0 after the next tick, and no match is set.
